mult_share_arb: RTL and testbench

MULT_SHARE_ARB -- requirements
Module: mult_share_arb

---
 rtl/mult_share_arb_pkg.sv | 20 ++
 rtl/mult_share_arb_if.sv | 44 ++++
 rtl/mult_share_arb_rr_arbiter.sv | 43 ++++
 rtl/mult_share_arb.sv | 120 ++++++++++++
 tb/tb_mult_share_arb.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_share_arb_pkg.sv
// mult_share_arb_pkg
//   Shared constants for the shared-multiplier arbiter slice: default
//   requester count, operand widths, multiplier latency, and the width of
//   the requester id carried alongside each operation.
package mult_share_arb_pkg;

    localparam int DEF_N_REQ   = 3;
    localparam int DEF_A_LEN   = 8;
    localparam int DEF_B_LEN   = 8;
    localparam int DEF_MUL_LAT = 4;

    // Id width for n requesters; a single requester still gets one bit so
    // every id vector has a legal nonzero width.
    function automatic int calc_tag_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int TAG_W = calc_tag_w(DEF_N_REQ);

endpackage

// File: rtl/mult_share_arb_if.sv
// mult_share_arb_if
//   Bundles the requester-side handshake and the external multiplier
//   operand/result buses of mult_share_arb.
//   Requester side : ce, req, a_in, b_in -> gnt, res, res_valid, err
//   Multiplier side: mul_A/mul_A_valid, mul_B/mul_B_valid out; mul_S/mul_S_valid in
//   Modports: slave  = the arbiter block
//             master = the environment (requesters + multiplier)
interface mult_share_arb_if
    import mult_share_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int A_LEN = DEF_A_LEN,
    parameter int B_LEN = DEF_B_LEN
);

    logic                     ce;
    logic [N_REQ-1:0]         req;
    logic [N_REQ*A_LEN-1:0]   a_in;
    logic [N_REQ*B_LEN-1:0]   b_in;
    logic [N_REQ-1:0]         gnt;
    logic [A_LEN+B_LEN-1:0]   res;
    logic [N_REQ-1:0]         res_valid;
    logic                     err;

    logic [A_LEN-1:0]         mul_A;
    logic                     mul_A_valid;
    logic [B_LEN-1:0]         mul_B;
    logic                     mul_B_valid;
    logic [A_LEN+B_LEN-1:0]   mul_S;
    logic                     mul_S_valid;

    modport slave (
        input  ce, req, a_in, b_in, mul_S, mul_S_valid,
        output gnt, res, res_valid, err,
               mul_A, mul_A_valid, mul_B, mul_B_valid
    );

    modport master (
        output ce, req, a_in, b_in, mul_S, mul_S_valid,
        input  gnt, res, res_valid, err,
               mul_A, mul_A_valid, mul_B, mul_B_valid
    );

endinterface

// File: rtl/mult_share_arb_rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin selector. Scans req starting at
//   position ptr and wrapping, granting the first active requester.
//   Ports: req (N_REQ) request vector, ptr (TW) scan start position,
//          gnt (N_REQ) one-hot grant, id (TW) binary index of the grant.
//   ptr must be below N_REQ.
module rr_arbiter
    import mult_share_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int TW    = TAG_W
) (
    input  logic [N_REQ-1:0] req,
    input  logic [TW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [TW-1:0]    id
);

    int   idx;
    logic found;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        gnt   = '0;
        id    = '0;
        idx   = 0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            // ptr < N_REQ, so one conditional subtract implements the wrap.
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                id       = TW'(idx);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_share_arb.sv
// mult_share_arb
//   Time-shares one external pipelined unsigned multiplier among N_REQ
//   requesters. Each ce-cycle at most one requester is granted round-robin;
//   its operands are registered onto mul_A/mul_B with a one-cycle valid.
//   A (valid, id) tag rides a MUL_LAT-deep shift pipe in lockstep with the
//   multiplier so the returning product can be steered to its owner.
//   Ports: clk, rst_n (async, active-low)
//          bus  : mult_share_arb_if.slave (requester + multiplier buses)
module mult_share_arb
    import mult_share_arb_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int A_LEN   = DEF_A_LEN,
    parameter int B_LEN   = DEF_B_LEN,
    parameter int MUL_LAT = DEF_MUL_LAT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mult_share_arb_if.slave       bus
);

    localparam int TW = calc_tag_w(N_REQ);

    logic [N_REQ-1:0]              req_eff;
    logic [N_REQ-1:0]              arb_gnt;
    logic [TW-1:0]                 arb_id;
    logic                          grant;
    logic [TW-1:0]                 ptr;
    logic [TW-1:0]                 ptr_next;

    logic [A_LEN-1:0]              mul_a_q;
    logic [B_LEN-1:0]              mul_b_q;
    logic                          issue_vld;
    logic [TW-1:0]                 issue_id;

    logic [MUL_LAT-1:0]            tag_vld;
    logic [MUL_LAT-1:0][TW-1:0]    tag_id;
    logic                          tag_out_vld;
    logic [TW-1:0]                 tag_out_id;
    logic                          err_q;

    // Requests are masked while stalled or in reset so gnt is quiet then.
    assign req_eff = (rst_n && bus.ce) ? bus.req : '0;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .TW    (TW)
    ) u_arb (
        .req (req_eff),
        .ptr (ptr),
        .gnt (arb_gnt),
        .id  (arb_id)
    );

    assign bus.gnt = arb_gnt;
    assign grant   = |arb_gnt;
    assign ptr_next = (arb_id == TW'(N_REQ - 1)) ? '0 : arb_id + TW'(1);

    // Issue stage and tag pipe. The issue register lines up with the
    // multiplier input; the tag pipe then matches the multiplier's MUL_LAT
    // stages, giving 1+MUL_LAT ce-cycles from gnt to result.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            ptr       <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            issue_vld <= 1'b0;
            issue_id  <= '0;
            // NOTE: the tag pipe is a shift register that must be reset:
            // stale valid bits would otherwise produce results for
            // operations discarded by the reset.
            tag_vld   <= '0;
            tag_id    <= '0;
            err_q     <= 1'b0;
        end else if (bus.ce) begin
            issue_vld <= grant;
            if (grant) begin
                ptr      <= ptr_next;
                mul_a_q  <= bus.a_in[int'(arb_id)*A_LEN +: A_LEN];
                mul_b_q  <= bus.b_in[int'(arb_id)*B_LEN +: B_LEN];
                issue_id <= arb_id;
            end

            tag_vld[0] <= issue_vld;
            tag_id[0]  <= issue_id;
            for (int i = 1; i < MUL_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end

            // A result without a tag, or a tag without a result, means the
            // multiplier latency does not match MUL_LAT.
            if (tag_out_vld != bus.mul_S_valid) begin
                err_q <= 1'b1;
            end
        end
    end

    assign tag_out_vld = tag_vld[MUL_LAT-1];
    assign tag_out_id  = tag_id[MUL_LAT-1];

    assign bus.mul_A       = mul_a_q;
    assign bus.mul_B       = mul_b_q;
    assign bus.mul_A_valid = issue_vld;
    assign bus.mul_B_valid = issue_vld;
    assign bus.res         = bus.mul_S;
    assign bus.err         = err_q;

    // Steer the returning product to its owner. Gated by ce so a result
    // parked at the pipe output during a stall is presented only once.
    always_comb begin
        bus.res_valid = '0;
        if (rst_n && bus.ce && tag_out_vld && bus.mul_S_valid) begin
            bus.res_valid[tag_out_id] = 1'b1;
        end
    end

endmodule

// File: tb/tb_mult_share_arb.sv
// tb_mult_share_arb
//   Directed bench for mult_share_arb with a behavioural 4-stage unsigned
//   multiplier attached to the multiplier side of the interface.
//   Cycle n starts 1 time unit after a rising edge; checks sample on the
//   falling edge inside the cycle.
module tb_mult_share_arb;
    import mult_share_arb_pkg::*;

    localparam int N   = 3;
    localparam int AL  = 8;
    localparam int BL  = 8;
    localparam int LAT = 4;
    localparam int PW  = AL + BL;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic spur  = 1'b0;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    mult_share_arb_if #(.N_REQ(N), .A_LEN(AL), .B_LEN(BL)) bus ();

    mult_share_arb #(
        .N_REQ   (N),
        .A_LEN   (AL),
        .B_LEN   (BL),
        .MUL_LAT (LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Multiplier model: LAT ce-gated stages, cleared by the same reset.
    logic [LAT-1:0] m_vld;
    logic [PW-1:0]  m_prod [LAT];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vld <= '0;
            for (int i = 0; i < LAT; i++) m_prod[i] <= '0;
        end else if (bus.ce) begin
            m_vld     <= {m_vld[LAT-2:0], bus.mul_A_valid};
            m_prod[0] <= PW'(bus.mul_A) * PW'(bus.mul_B);
            for (int i = 1; i < LAT; i++) m_prod[i] <= m_prod[i-1];
        end
    end

    assign bus.mul_S       = m_prod[LAT-1];
    assign bus.mul_S_valid = m_vld[LAT-1] | spur;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_op(input int i, input int a, input int b);
        bus.a_in[i*AL +: AL] = AL'(a);
        bus.b_in[i*BL +: BL] = BL'(b);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        bus.ce   = 1'b1;
        bus.req  = '0;
        bus.a_in = '0;
        bus.b_in = '0;
        spur     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        bus.ce   = 1'b1;
        bus.req  = 3'b111;
        bus.a_in = '1;
        bus.b_in = '1;
        spur     = 1'b0;
        tick();
        tick();
        mid();
        n_total++;
        if (bus.gnt !== 3'b000) $display("FAIL reset_gnt: got %b expected 000", bus.gnt); else n_pass++;
        n_total++;
        if (bus.res_valid !== 3'b000) $display("FAIL reset_res_valid: got %b expected 000", bus.res_valid); else n_pass++;
        n_total++;
        if (bus.mul_A_valid !== 1'b0 || bus.mul_B_valid !== 1'b0)
            $display("FAIL reset_mul_valid: got %b%b expected 00", bus.mul_A_valid, bus.mul_B_valid);
        else n_pass++;
        n_total++;
        if (bus.mul_A !== 8'd0 || bus.mul_B !== 8'd0)
            $display("FAIL reset_mul_ops: got %0d,%0d expected 0,0", bus.mul_A, bus.mul_B);
        else n_pass++;
        n_total++;
        if (bus.err !== 1'b0) $display("FAIL reset_err: got %b expected 0", bus.err); else n_pass++;
        tick();
    endtask

    task automatic test_single();
        logic [2:0] exp_gnt, exp_rv;
        do_reset();
        set_op(0, 200, 3);
        for (int c = 0; c < 8; c++) begin
            bus.req = (c == 0) ? 3'b001 : 3'b000;
            mid();
            exp_gnt = (c == 0) ? 3'b001 : 3'b000;
            exp_rv  = (c == 5) ? 3'b001 : 3'b000;
            n_total++;
            if (bus.gnt !== exp_gnt) $display("FAIL single_gnt c%0d: got %b expected %b", c, bus.gnt, exp_gnt); else n_pass++;
            n_total++;
            if (bus.res_valid !== exp_rv) $display("FAIL single_res_valid c%0d: got %b expected %b", c, bus.res_valid, exp_rv); else n_pass++;
            if (c == 1) begin
                n_total++;
                if (bus.mul_A_valid !== 1'b1 || bus.mul_A !== 8'd200 || bus.mul_B !== 8'd3)
                    $display("FAIL single_issue: got v=%b a=%0d b=%0d expected v=1 a=200 b=3", bus.mul_A_valid, bus.mul_A, bus.mul_B);
                else n_pass++;
            end
            if (c == 2) begin
                n_total++;
                if (bus.mul_A_valid !== 1'b0) $display("FAIL single_pulse: got %b expected 0", bus.mul_A_valid); else n_pass++;
            end
            if (c == 5) begin
                n_total++;
                if (bus.res !== 16'd600) $display("FAIL single_res: got %0d expected 600", bus.res); else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_simultaneous();
        logic [2:0]  req_hold, exp_gnt, exp_rv;
        logic [15:0] exp_res [3];
        exp_res[0] = 16'd100;
        exp_res[1] = 16'd100;
        exp_res[2] = 16'd65025;
        do_reset();
        set_op(0, 10, 10);
        set_op(1, 20, 5);
        set_op(2, 255, 255);
        req_hold = 3'b111;
        for (int c = 0; c < 10; c++) begin
            bus.req = req_hold;
            mid();
            exp_gnt = (c < 3) ? 3'(1 << c) : 3'b000;
            exp_rv  = (c >= 5 && c <= 7) ? 3'(1 << (c - 5)) : 3'b000;
            n_total++;
            if (bus.gnt !== exp_gnt) $display("FAIL simul_gnt c%0d: got %b expected %b", c, bus.gnt, exp_gnt); else n_pass++;
            n_total++;
            if (bus.res_valid !== exp_rv) $display("FAIL simul_res_valid c%0d: got %b expected %b", c, bus.res_valid, exp_rv); else n_pass++;
            if (c >= 5 && c <= 7) begin
                n_total++;
                if (bus.res !== exp_res[c-5]) $display("FAIL simul_res c%0d: got %0d expected %0d", c, bus.res, exp_res[c-5]); else n_pass++;
            end
            req_hold = req_hold & ~exp_gnt;
            tick();
        end
    endtask

    task automatic test_fairness();
        logic [2:0]  exp_gnt, exp_rv;
        logic [15:0] exp_r;
        do_reset();
        set_op(0, 7, 9);
        set_op(1, 12, 11);
        set_op(2, 1, 1);
        for (int c = 0; c < 12; c++) begin
            bus.req = (c < 6) ? 3'b011 : 3'b000;
            mid();
            exp_gnt = (c < 6) ? ((c % 2 == 1) ? 3'b010 : 3'b001) : 3'b000;
            exp_rv  = (c >= 5 && c <= 10) ? (((c - 5) % 2 == 1) ? 3'b010 : 3'b001) : 3'b000;
            exp_r   = ((c - 5) % 2 == 1) ? 16'd132 : 16'd63;
            n_total++;
            if (bus.gnt !== exp_gnt) $display("FAIL fair_gnt c%0d: got %b expected %b", c, bus.gnt, exp_gnt); else n_pass++;
            n_total++;
            if (bus.res_valid !== exp_rv) $display("FAIL fair_res_valid c%0d: got %b expected %b", c, bus.res_valid, exp_rv); else n_pass++;
            if (c >= 5 && c <= 10) begin
                n_total++;
                if (bus.res !== exp_r) $display("FAIL fair_res c%0d: got %0d expected %0d", c, bus.res, exp_r); else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_stall();
        logic [2:0] exp_gnt, exp_rv;
        do_reset();
        set_op(1, 15, 17);
        set_op(0, 9, 9);
        for (int c = 0; c < 11; c++) begin
            bus.ce  = !(c >= 2 && c <= 4);
            // Requester 0 raises req during the stall and drops it ungranted.
            bus.req = (c == 0) ? 3'b010 : ((c == 3) ? 3'b001 : 3'b000);
            mid();
            exp_gnt = (c == 0) ? 3'b010 : 3'b000;
            exp_rv  = (c == 8) ? 3'b010 : 3'b000;
            n_total++;
            if (bus.gnt !== exp_gnt) $display("FAIL stall_gnt c%0d: got %b expected %b", c, bus.gnt, exp_gnt); else n_pass++;
            n_total++;
            if (bus.res_valid !== exp_rv) $display("FAIL stall_res_valid c%0d: got %b expected %b", c, bus.res_valid, exp_rv); else n_pass++;
            if (c >= 2 && c <= 4) begin
                n_total++;
                if (bus.mul_A_valid !== 1'b0 || bus.mul_A !== 8'd15)
                    $display("FAIL stall_hold c%0d: got v=%b a=%0d expected v=0 a=15", c, bus.mul_A_valid, bus.mul_A);
                else n_pass++;
            end
            if (c == 8) begin
                n_total++;
                if (bus.res !== 16'd255) $display("FAIL stall_res: got %0d expected 255", bus.res); else n_pass++;
            end
            tick();
        end
        bus.ce = 1'b1;
    endtask

    task automatic test_reset_midflight();
        logic [2:0] exp_gnt;
        do_reset();
        set_op(0, 3, 4);
        set_op(1, 5, 6);
        for (int c = 0; c < 14; c++) begin
            if (c == 2) rst_n = 1'b0;
            if (c == 3) rst_n = 1'b1;
            case (c)
                0:       bus.req = 3'b011;
                1:       bus.req = 3'b010;
                2:       bus.req = 3'b111;
                13:      bus.req = 3'b111;
                default: bus.req = 3'b000;
            endcase
            mid();
            case (c)
                0:       exp_gnt = 3'b001;
                1:       exp_gnt = 3'b010;
                13:      exp_gnt = 3'b001;
                default: exp_gnt = 3'b000;
            endcase
            n_total++;
            if (bus.gnt !== exp_gnt) $display("FAIL rstmid_gnt c%0d: got %b expected %b", c, bus.gnt, exp_gnt); else n_pass++;
            if (c >= 2) begin
                n_total++;
                if (bus.res_valid !== 3'b000) $display("FAIL rstmid_res_valid c%0d: got %b expected 000", c, bus.res_valid); else n_pass++;
                n_total++;
                if (bus.err !== 1'b0) $display("FAIL rstmid_err c%0d: got %b expected 0", c, bus.err); else n_pass++;
            end
            tick();
        end
        bus.req = '0;
    endtask

    task automatic test_mismatch();
        logic       exp_err;
        logic [2:0] exp_rv;
        do_reset();
        set_op(0, 2, 2);
        for (int c = 0; c < 11; c++) begin
            spur    = (c == 2);
            bus.req = (c == 4) ? 3'b001 : 3'b000;
            mid();
            exp_err = (c >= 3);
            exp_rv  = (c == 9) ? 3'b001 : 3'b000;
            n_total++;
            if (bus.err !== exp_err) $display("FAIL mism_err c%0d: got %b expected %b", c, bus.err, exp_err); else n_pass++;
            n_total++;
            if (bus.res_valid !== exp_rv) $display("FAIL mism_res_valid c%0d: got %b expected %b", c, bus.res_valid, exp_rv); else n_pass++;
            if (c == 9) begin
                n_total++;
                if (bus.res !== 16'd4) $display("FAIL mism_res: got %0d expected 4", bus.res); else n_pass++;
            end
            tick();
        end
        spur = 1'b0;
    endtask

    initial begin
        bus.ce   = 1'b1;
        bus.req  = '0;
        bus.a_in = '0;
        bus.b_in = '0;
        #1;
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_stall();
        test_reset_midflight();
        test_mismatch();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete within 100000 time units");
        $fatal(1);
    end

endmodule
